lfsr_rng_seq: RTL and testbench

Parametrised pseudo-random word generator. It is the next generation of the team's fixed 32-bit LFSR source, adding:
- configurable width and tap polynomial
- a seed handshake with post-seed warm-up discard
- a valid/ready output stream that advances only on consumption
- lock-up detection, with an optional repetition health test

It sits between the seeding logic and downstream consumers (mask and nonce generators). Output is pseudo-random only; it is not a cryptographic source.

---
 rtl/lfsr_rng_seq.sv | 161 ++++++++++++++++
 tb/tb_lfsr_rng_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_seq.sv
// Parametrised Fibonacci LFSR word source with seed handshake, warm-up discard, valid/ready
// output and lock-up detection. Define RNG_HEALTH_TEST_EN to add the repetition health test.
module lfsr_rng_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [63:0] TAPS      = 64'h0000_0000_8020_0003,
    parameter int unsigned WARMUP    = 64,
    parameter int unsigned REP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_valid,
    input  logic [WIDTH-1:0] seed,
    output logic             seed_ready,
    output logic             seed_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             warming,
    output logic             lockup_err,
    output logic             health_fail
);

    localparam int unsigned CntW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WIDTH-1:0] TapMask = TAPS[WIDTH-1:0];
    localparam logic [CntW-1:0] WarmLast = (WARMUP > 0) ? CntW'(WARMUP - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StRun,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             lock_q, lock_d;

    logic [WIDTH-1:0] lfsr_next;
    logic             next_zero;
    logic             seed_accept;
    logic             xfer;
    logic             rep_trip;

    assign seed_ready  = ~rst;
    assign seed_accept = seed_valid & seed_ready;
    assign out_valid   = (state_q == StRun);
    assign warming     = (state_q == StWarmup);
    assign out_data    = lfsr_q;
    assign seed_zero   = zero_q;
    assign lockup_err  = lock_q;
    assign xfer        = out_valid & out_ready;

    assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TapMask)};
    assign next_zero = (lfsr_next == '0);

`ifdef RNG_HEALTH_TEST_EN
    localparam int unsigned RepW = $clog2(REP_LIMIT + 1);

    logic [WIDTH-1:0] last_q, last_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             hfail_q, hfail_d;

    // A zero count means no word has been delivered since the last seed.
    always_comb begin
        last_d   = last_q;
        rep_d    = rep_q;
        rep_trip = 1'b0;
        if (seed_accept) begin
            rep_d = '0;
        end else if (xfer) begin
            last_d   = lfsr_q;
            rep_d    = (rep_q != '0 && lfsr_q == last_q) ? rep_q + RepW'(1) : RepW'(1);
            rep_trip = (rep_d == RepW'(REP_LIMIT));
        end
        hfail_d = seed_accept ? 1'b0 : (hfail_q | rep_trip);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= '0;
            rep_q   <= '0;
            hfail_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            rep_q   <= rep_d;
            hfail_q <= hfail_d;
        end
    end

    assign health_fail = hfail_q;
`else
    assign rep_trip    = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        zero_d  = 1'b0;
        lock_d  = lock_q;
        if (seed_accept) begin
            lfsr_d  = (seed == '0) ? WIDTH'(1) : seed;
            zero_d  = (seed == '0);
            cnt_d   = '0;
            lock_d  = 1'b0;
            state_d = (WARMUP == 0) ? StRun : StWarmup;
        end else begin
            case (state_q)
                StWarmup: begin
                    if (next_zero) begin
                        state_d = StFault;
                        lock_d  = 1'b1;
                    end else begin
                        lfsr_d = lfsr_next;
                        if (cnt_q == WarmLast) begin
                            state_d = StRun;
                        end
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StRun: begin
                    // The zero state is never loaded, so it can never be offered as valid.
                    if (xfer) begin
                        if (next_zero) begin
                            state_d = StFault;
                            lock_d  = 1'b1;
                        end else if (rep_trip) begin
                            state_d = StFault;
                        end else begin
                            lfsr_d = lfsr_next;
                        end
                    end
                end
                StIdle, StFault: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rng_seq.sv
// Self-checking bench for lfsr_rng_seq: four 8-bit instances covering sequencing, warm-up,
// lock-up and the repetition health test (RNG_HEALTH_TEST_EN selects its expectations).
module tb_lfsr_rng_seq;

    logic       clk;
    logic       rst;
    logic       sv   [4];
    logic [7:0] sd   [4];
    logic       rdy  [4];
    logic       srdy [4];
    logic       sz   [4];
    logic       ov   [4];
    logic [7:0] od   [4];
    logic       wm   [4];
    logic       le   [4];
    logic       hf   [4];

    int         total;
    int         bad;
    logic [7:0] exp_q[$];

    lfsr_rng_seq #(.WIDTH(8), .TAPS(64'hB8), .WARMUP(0), .REP_LIMIT(4)) u_main (
        .clk(clk), .rst(rst), .seed_valid(sv[0]), .seed(sd[0]), .seed_ready(srdy[0]),
        .seed_zero(sz[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
        .warming(wm[0]), .lockup_err(le[0]), .health_fail(hf[0]));

    lfsr_rng_seq #(.WIDTH(8), .TAPS(64'hB8), .WARMUP(4), .REP_LIMIT(4)) u_warm (
        .clk(clk), .rst(rst), .seed_valid(sv[1]), .seed(sd[1]), .seed_ready(srdy[1]),
        .seed_zero(sz[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
        .warming(wm[1]), .lockup_err(le[1]), .health_fail(hf[1]));

    lfsr_rng_seq #(.WIDTH(8), .TAPS(64'h00), .WARMUP(0), .REP_LIMIT(4)) u_lock (
        .clk(clk), .rst(rst), .seed_valid(sv[2]), .seed(sd[2]), .seed_ready(srdy[2]),
        .seed_zero(sz[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od[2]),
        .warming(wm[2]), .lockup_err(le[2]), .health_fail(hf[2]));

    lfsr_rng_seq #(.WIDTH(8), .TAPS(64'h01), .WARMUP(0), .REP_LIMIT(4)) u_hlth (
        .clk(clk), .rst(rst), .seed_valid(sv[3]), .seed(sd[3]), .seed_ready(srdy[3]),
        .seed_zero(sz[3]), .out_valid(ov[3]), .out_ready(rdy[3]), .out_data(od[3]),
        .warming(wm[3]), .lockup_err(le[3]), .health_fail(hf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [7:0] model_step(input logic [7:0] s, input logic [7:0] taps);
        return {s[6:0], ^(s & taps)};
    endfunction

    task automatic push_seq(input logic [7:0] s0, input logic [7:0] taps, input int n);
        logic [7:0] s;
        s = s0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s);
            s = model_step(s, taps);
        end
    endtask

    // Seed offered for one edge; returns at the negedge after the accepting edge.
    task automatic seed_dut(input int k, input logic [7:0] v);
        @(negedge clk);
        sv[k] = 1'b1;
        sd[k] = v;
        @(negedge clk);
        sv[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sv[k] = 1'b0; sd[k] = 8'h00; rdy[k] = 1'b0;
        end
        sv[0] = 1'b1; sd[0] = 8'h5A;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total += 7;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL rst_valid%0d got=%b want=0", k, ov[k]); end
            if (od[k] !== 8'h00) begin bad++; $display("FAIL rst_data%0d got=%h want=00", k, od[k]); end
            if (wm[k] !== 1'b0) begin bad++; $display("FAIL rst_warm%0d got=%b want=0", k, wm[k]); end
            if (sz[k] !== 1'b0) begin bad++; $display("FAIL rst_szero%0d got=%b want=0", k, sz[k]); end
            if (le[k] !== 1'b0) begin bad++; $display("FAIL rst_lock%0d got=%b want=0", k, le[k]); end
            if (hf[k] !== 1'b0) begin bad++; $display("FAIL rst_health%0d got=%b want=0", k, hf[k]); end
            if (srdy[k] !== 1'b0) begin bad++; $display("FAIL rst_sready%0d got=%b want=0", k, srdy[k]); end
        end
        rst = 1'b0;
        sv[0] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total += 2;
            if (srdy[k] !== 1'b1) begin bad++; $display("FAIL idle_sready%0d got=%b want=1", k, srdy[k]); end
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL idle_valid%0d got=%b want=0", k, ov[k]); end
        end
    endtask

    task automatic test_sequence;
        logic [7:0] e;
        exp_q.delete();
        push_seq(8'h01, 8'hB8, 5);
        rdy[0] = 1'b1;
        seed_dut(0, 8'h01);
        total++;
        if (sz[0] !== 1'b0) begin bad++; $display("FAIL seq_szero got=%b want=0", sz[0]); end
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            total += 2;
            if (ov[0] !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b want=1", i, ov[0]); end
            if (od[0] !== e) begin bad++; $display("FAIL seq_word%0d got=%h want=%h", i, od[0], e); end
            @(negedge clk);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_period_backpressure;
        logic [7:0] e;
        int         zeros;
        zeros = 0;
        exp_q.delete();
        push_seq(8'h01, 8'hB8, 255);
        rdy[0] = 1'b1;
        seed_dut(0, 8'h01);
        for (int i = 0; i < 255; i++) begin
            e = exp_q.pop_front();
            if (od[0] == 8'h00) zeros++;
            total++;
            if (ov[0] !== 1'b1 || od[0] !== e) begin
                bad++;
                $display("FAIL period_word%0d got=%h/%b want=%h/1", i, od[0], ov[0], e);
            end
            @(negedge clk);
        end
        rdy[0] = 1'b0;
        total += 2;
        if (od[0] !== 8'h01) begin bad++; $display("FAIL period_wrap got=%h want=01", od[0]); end
        if (zeros != 0) begin bad++; $display("FAIL period_zero got=%0d want=0", zeros); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (ov[0] !== 1'b1 || od[0] !== 8'h01) begin
                bad++;
                $display("FAIL hold%0d got=%h/%b want=01/1", i, od[0], ov[0]);
            end
        end
    endtask

    task automatic test_warmup;
        logic [7:0] e;
        exp_q.delete();
        push_seq(8'h01, 8'hB8, 7);
        rdy[1] = 1'b1;
        seed_dut(1, 8'h01);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total += 3;
            if (wm[1] !== 1'b1) begin bad++; $display("FAIL warm_flag%0d got=%b want=1", i, wm[1]); end
            if (ov[1] !== 1'b0) begin bad++; $display("FAIL warm_valid%0d got=%b want=0", i, ov[1]); end
            if (od[1] !== e) begin bad++; $display("FAIL warm_state%0d got=%h want=%h", i, od[1], e); end
            @(negedge clk);
        end
        total += 2;
        if (wm[1] !== 1'b0) begin bad++; $display("FAIL warm_end got=%b want=0", wm[1]); end
        if (od[1] !== 8'h11) begin bad++; $display("FAIL warm_first got=%h want=11", od[1]); end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[1] !== 1'b1 || od[1] !== e) begin
                bad++;
                $display("FAIL warm_word%0d got=%h/%b want=%h/1", i, od[1], ov[1], e);
            end
            @(negedge clk);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_zero_seed;
        logic [7:0] e;
        exp_q.delete();
        push_seq(8'h01, 8'hB8, 4);
        rdy[0] = 1'b1;
        seed_dut(0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total += 2;
            if (sz[0] !== (i == 0)) begin
                bad++;
                $display("FAIL zero_pulse%0d got=%b want=%b", i, sz[0], (i == 0));
            end
            if (ov[0] !== 1'b1 || od[0] !== e) begin
                bad++;
                $display("FAIL zero_word%0d got=%h/%b want=%h/1", i, od[0], ov[0], e);
            end
            @(negedge clk);
        end
    endtask

    // Reseed while a transfer is taking place: the seed defines the next word.
    task automatic test_seed_during_transfer;
        logic [7:0] e;
        exp_q.delete();
        push_seq(8'h55, 8'hB8, 3);
        rdy[0] = 1'b1;
        seed_dut(0, 8'h55);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[0] !== 1'b1 || od[0] !== e) begin
                bad++;
                $display("FAIL reseed_word%0d got=%h/%b want=%h/1", i, od[0], ov[0], e);
            end
            @(negedge clk);
        end
        rdy[0] = 1'b0;
    endtask

    task automatic test_lockup;
        rdy[2] = 1'b1;
        seed_dut(2, 8'h80);
        total += 2;
        if (ov[2] !== 1'b1 || od[2] !== 8'h80) begin
            bad++; $display("FAIL lock_first got=%h/%b want=80/1", od[2], ov[2]);
        end
        if (le[2] !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", le[2]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total += 2;
            if (le[2] !== 1'b1) begin bad++; $display("FAIL lock_err%0d got=%b want=1", i, le[2]); end
            if (ov[2] !== 1'b0 || od[2] !== 8'h80) begin
                bad++; $display("FAIL lock_frozen%0d got=%h/%b want=80/0", i, od[2], ov[2]);
            end
        end
        seed_dut(2, 8'h01);
        total += 2;
        if (le[2] !== 1'b0) begin bad++; $display("FAIL lock_clear got=%b want=0", le[2]); end
        if (ov[2] !== 1'b1 || od[2] !== 8'h01) begin
            bad++; $display("FAIL lock_reseed got=%h/%b want=01/1", od[2], ov[2]);
        end
        @(negedge clk);
        total++;
        if (od[2] !== 8'h02) begin bad++; $display("FAIL lock_step got=%h want=02", od[2]); end
        rdy[2] = 1'b0;
    endtask

    task automatic test_health;
        logic [7:0] e;
        exp_q.delete();
        push_seq(8'hFF, 8'h01, 4);
        rdy[3] = 1'b1;
        seed_dut(3, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            total++;
            if (ov[3] !== 1'b1 || od[3] !== e) begin
                bad++; $display("FAIL hlth_word%0d got=%h/%b want=%h/1", i, od[3], ov[3], e);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            total += 2;
`ifdef RNG_HEALTH_TEST_EN
            if (hf[3] !== 1'b1) begin bad++; $display("FAIL hlth_flag%0d got=%b want=1", i, hf[3]); end
            if (ov[3] !== 1'b0) begin bad++; $display("FAIL hlth_valid%0d got=%b want=0", i, ov[3]); end
`else
            if (hf[3] !== 1'b0) begin bad++; $display("FAIL hlth_flag%0d got=%b want=0", i, hf[3]); end
            if (ov[3] !== 1'b1 || od[3] !== 8'hFF) begin
                bad++; $display("FAIL hlth_stream%0d got=%h/%b want=ff/1", i, od[3], ov[3]);
            end
`endif
            @(negedge clk);
        end
        seed_dut(3, 8'h01);
        total += 2;
        if (hf[3] !== 1'b0) begin bad++; $display("FAIL hlth_clear got=%b want=0", hf[3]); end
        if (ov[3] !== 1'b1 || od[3] !== 8'h01) begin
            bad++; $display("FAIL hlth_reseed got=%h/%b want=01/1", od[3], ov[3]);
        end
        @(negedge clk);
        total++;
        if (od[3] !== 8'h03) begin bad++; $display("FAIL hlth_step got=%h want=03", od[3]); end
        rdy[3] = 1'b0;
    endtask

    // Reset mid-stream with a concurrent seed offer: the seed must be ignored.
    task automatic test_mid_reset;
        rdy[0] = 1'b1;
        seed_dut(0, 8'h01);
        @(negedge clk);
        rst   = 1'b1;
        sv[0] = 1'b1;
        sd[0] = 8'h33;
        @(negedge clk);
        total += 3;
        if (ov[0] !== 1'b0 || od[0] !== 8'h00) begin
            bad++; $display("FAIL mrst_state got=%h/%b want=00/0", od[0], ov[0]);
        end
        if (srdy[0] !== 1'b0) begin bad++; $display("FAIL mrst_sready got=%b want=0", srdy[0]); end
        if (sz[0] !== 1'b0) begin bad++; $display("FAIL mrst_szero got=%b want=0", sz[0]); end
        rst   = 1'b0;
        sv[0] = 1'b0;
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || od[0] !== 8'h00) begin
            bad++; $display("FAIL mrst_idle got=%h/%b want=00/0", od[0], ov[0]);
        end
        rdy[0] = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_sequence();
        test_period_backpressure();
        test_warmup();
        test_zero_seed();
        test_seed_during_transfer();
        test_lockup();
        test_health();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
